// File: rtl/iter_div_param.sv
// Multi-cycle restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock,
// with optional two's-complement operands handled by magnitude division plus a sign-fix cycle.
module iter_div_param #(
    parameter int DW        = 8,
    parameter int VW        = 4,
    parameter int SIGNED_EN = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          signed_op,
    input  logic [DW-1:0] A,
    input  logic [VW-1:0] B,
    output logic          busy,
    output logic          done,
    output logic          div_zero,
    output logic [DW-1:0] Q,
    output logic [VW-1:0] R
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          neg_q_q, neg_q_d;
    logic          neg_r_q, neg_r_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW-1:0] r_q, r_d;
    logic          dz_q, dz_d;

    logic          sgn, a_neg, b_neg, accept;
    logic [DW-1:0] a_mag;
    logic [VW-1:0] b_mag;
    logic [VW:0]   trial;

    always_comb begin
        sgn    = (SIGNED_EN != 0) && signed_op;
        a_neg  = sgn & A[DW-1];
        b_neg  = sgn & B[VW-1];
        a_mag  = a_neg ? -A : A;
        b_mag  = b_neg ? -B : B;
        // Partial remainder stays below the divisor, so the shifted value fits VW+1 bits
        // and the trial's top bit is the borrow.
        trial  = {rem_q, dvd_q[DW-1]} - {1'b0, dvs_q};
        accept = start && (state_q == IDLE || state_q == DONE);

        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (B == '0) begin
                        q_d     = '1;
                        r_d     = '0;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        rem_d   = '0;
                        neg_q_d = a_neg ^ b_neg;
                        neg_r_d = a_neg;
                        cnt_d   = CW'(DW);
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // Quotient bits shift into the bottom of the dividend register.
                if (!trial[VW]) begin
                    rem_d = trial[VW-1:0];
                    dvd_d = {dvd_q[DW-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[VW-2:0], dvd_q[DW-1]};
                    dvd_d = {dvd_q[DW-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                q_d     = neg_q_q ? -dvd_q : dvd_q;
                r_d     = neg_r_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q == CALC) || (state_q == FIX);
    assign done     = (state_q == DONE);
    assign div_zero = dz_q;
    assign Q        = q_q;
    assign R        = r_q;
endmodule

// File: tb/tb_iter_div_param.sv
// Scoreboard bench for iter_div_param: a signed-capable instance plus a SIGNED_EN=0 instance.
module tb_iter_div_param;
    localparam int DW = 8;
    localparam int VW = 4;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
        int            cyc;
        int            bsy;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, start_u = 1'b0, signed_op = 1'b0;
    logic [DW-1:0] A = '0;
    logic [VW-1:0] B = '0;
    logic busy, done, div_zero, busy_u, done_u, div_zero_u;
    logic [DW-1:0] Q, Q_u;
    logic [VW-1:0] R, R_u;

    int cyc = 0, n_pass = 0, n_tot = 0, bcnt = 0;
    exp_t sb[$], sbu[$];

    iter_div_param #(.DW(DW), .VW(VW), .SIGNED_EN(1)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_op(signed_op), .A(A), .B(B),
        .busy(busy), .done(done), .div_zero(div_zero), .Q(Q), .R(R));

    iter_div_param #(.DW(DW), .VW(VW), .SIGNED_EN(0)) dut_u (
        .clk(clk), .reset(reset), .start(start_u), .signed_op(signed_op), .A(A), .B(B),
        .busy(busy_u), .done(done_u), .div_zero(div_zero_u), .Q(Q_u), .R(R_u));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor for the signed-capable instance
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            chk("busy_with_done", 32'(busy), 32'd0);
            if (sb.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_done: got Q=%0h R=%0h expected no done (cycle %0d)", Q, R, cyc);
            end else begin
                e = sb.pop_front();
                chk("Q", 32'(Q), 32'(e.q));
                chk("R", 32'(R), 32'(e.r));
                chk("div_zero", 32'(div_zero), 32'(e.dz));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_cycles", 32'(bcnt), 32'(e.bsy));
            end
            bcnt = 0;
        end else if (busy) bcnt++;
        else bcnt = 0;
    end

    // Monitor for the unsigned-only instance
    always @(negedge clk) begin
        exp_t e;
        if (done_u) begin
            if (sbu.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_done_u: got Q=%0h R=%0h expected no done", Q_u, R_u);
            end else begin
                e = sbu.pop_front();
                chk("Q_u", 32'(Q_u), 32'(e.q));
                chk("R_u", 32'(R_u), 32'(e.r));
                chk("done_cycle_u", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic s,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edz);
        exp_t e;
        @(negedge clk);
        A = a; B = b; signed_op = s; start = 1'b1;
        e.q = eq; e.r = er; e.dz = edz;
        e.cyc = cyc + (edz ? 1 : DW + 2);
        e.bsy = edz ? 0 : DW + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || sbu.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0 || sbu.size() != 0) begin
            n_tot++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size() + sbu.size());
            sb.delete();
            sbu.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int n;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        chk("rst_Q", 32'(Q), 32'd0);
        chk("rst_R", 32'(R), 32'd0);
        reset = 1'b0;

        issue(8'd100, 4'd7, 1'b0, 8'd14, 4'd2, 1'b0);
        drain();
        issue(8'h9C, 4'd7, 1'b1, 8'hF2, 4'hE, 1'b0);
        drain();
        issue(8'h80, 4'hF, 1'b1, 8'h80, 4'h0, 1'b0);
        drain();
        issue(8'h07, 4'hE, 1'b1, 8'hFD, 4'h1, 1'b0);   // 7 / -2
        drain();
        issue(8'hF9, 4'hE, 1'b1, 8'h03, 4'hF, 1'b0);   // -7 / -2
        drain();
        issue(8'd55, 4'd0, 1'b0, 8'hFF, 4'h0, 1'b1);
        drain();
        issue(8'd9, 4'd3, 1'b0, 8'd3, 4'd0, 1'b0);
        drain();

        // Start pulsed mid-CALC with other operands must be ignored
        issue(8'd255, 4'd15, 1'b0, 8'd17, 4'd0, 1'b0);
        @(negedge clk);
        A = 8'd10; B = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset during the 4th CALC cycle aborts without a done
        @(negedge clk);
        A = 8'd200; B = 4'd3; signed_op = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_Q", 32'(Q), 32'd0);
        chk("abort_R", 32'(R), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (DW + 4) @(negedge clk);
        issue(8'd200, 4'd3, 1'b0, 8'd66, 4'd2, 1'b0);
        drain();

        // Back-to-back: start held through DONE, operands changed during CALC
        @(negedge clk);
        A = 8'd100; B = 4'd7; signed_op = 1'b0; start = 1'b1;
        e.q = 8'd14; e.r = 4'd2; e.dz = 1'b0; e.cyc = cyc + DW + 2; e.bsy = DW + 1;
        sb.push_back(e);
        e.q = 8'hF2; e.r = 4'hE; e.cyc = cyc + 2 * DW + 4;
        sb.push_back(e);
        @(negedge clk);
        A = 8'h9C; B = 4'd7; signed_op = 1'b1;
        repeat (DW + 2) @(negedge clk);
        start = 1'b0;
        drain();

        // SIGNED_EN=0 instance ignores signed_op
        @(negedge clk);
        A = 8'h9C; B = 4'd7; signed_op = 1'b1; start_u = 1'b1;
        e.q = 8'd22; e.r = 4'd2; e.dz = 1'b0; e.cyc = cyc + DW + 2; e.bsy = DW + 1;
        sbu.push_back(e);
        @(negedge clk);
        start_u = 1'b0;
        drain();

        n = sb.size() + sbu.size();
        chk("scoreboard_empty", 32'(n), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/iter_div_param.md
ITER_DIV_PARAM -- requirements
Module: iter_div_param

Interface
REQ-001 SHALL have parameter DW, default 8, dividend and quotient width (DW >= VW, VW >= 2).
REQ-002 SHALL have parameter VW, default 4, divisor and remainder width.
REQ-003 SHALL have parameter SIGNED_EN, default 1; when 1, signed division is available, and when 0, signed_op is ignored.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to launch a division with the current A, B and signed_op.
REQ-007 SHALL have port signed_op  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 SHALL have port A  input  DW  dividend.
REQ-009 SHALL have port B  input  VW  divisor.
REQ-010 SHALL have port busy  output  1  division in progress.
REQ-011 SHALL have port done  output  1  single-cycle result-valid pulse.
REQ-012 SHALL have port div_zero  output  1  last completed operation had B == 0.
REQ-013 SHALL have port Q  output  DW  quotient.
REQ-014 SHALL have port R  output  VW  remainder.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-016 SHALL accept start only in IDLE or DONE, sampling A, B and signed_op on that edge (e0).
REQ-017 SHALL ignore start while in CALC or FIX.
REQ-018 SHALL, on acceptance with B != 0, latch operand magnitudes (absolute values if signed mode is active), record the result signs, load the iteration counter with DW, and enter CALC.
REQ-019 SHALL in CALC perform one restoring shift/subtract step per clock, producing one quotient bit MSB-first, for exactly DW clocks (edges e1..eDW), then enter FIX.
REQ-020 SHALL in FIX, for one clock, apply sign correction: Q negated if sign(A) xor sign(B), R negated if sign(A) (truncating division); then enter DONE.
REQ-021 SHALL assert done only in DONE (the cycle after edge e(DW+1)); latency from accepted start to done = DW+2 clocks.
REQ-022 SHALL leave DONE after one cycle, to IDLE, or to CALC/DONE if start is accepted in that cycle.
REQ-023 SHALL assert busy in CALC and FIX only; busy and done never high together.
REQ-024 SHALL compute unsigned results as Q = A / B and R = A mod B; R < B always fits VW bits.
REQ-025 SHALL wrap the signed overflow case (most-negative A, B = -1) to Q = most-negative value, R = 0, with no flag.
REQ-026 SHALL, on acceptance with B == 0, go directly to DONE, set Q = all ones, R = 0 and div_zero = 1, giving done in the cycle after e0.
REQ-027 SHALL clear div_zero at the next accepted start with B != 0.
REQ-028 SHALL hold Q, R and div_zero stable from DONE until the next result is written in FIX or DONE.
REQ-029 SHALL NOT let input changes after e0 affect the operation in progress.

Reset
REQ-030 SHALL, while reset is high at a clock edge, enter IDLE and drive busy = 0, done = 0, div_zero = 0, Q = 0 and R = 0.
REQ-031 SHALL give reset priority over start and abort any operation in progress; no done is produced for an aborted operation.

Verification
REQ-032 SHALL verify (DW = 8, VW = 4) unsigned A = 100, B = 7 -> Q = 14, R = 2, done exactly 10 clocks after the start edge, busy high for 9 cycles.
REQ-033 SHALL verify signed A = 0x9C (-100), B = 7 -> Q = 0xF2 (-14), R = 0xE (-2); signed A = 0x80, B = 0xF (-1) -> Q = 0x80, R = 0.
REQ-034 SHALL verify A = 55, B = 0 -> done one cycle after the start edge, div_zero = 1, Q = 0xFF, R = 0; then A = 9, B = 3 -> div_zero = 0, Q = 3, R = 0.
REQ-035 SHALL verify that start pulsed during CALC with different operands is ignored and the first result (A = 255, B = 15 -> Q = 17, R = 0) is returned unchanged.
REQ-036 SHALL verify that reset asserted at the 4th CALC cycle gives busy = 0, Q = 0, R = 0 on the next cycle and no done pulse; a subsequent start then completes normally.
REQ-037 SHALL verify back-to-back operation (start held high through DONE gives a second result 10 clocks later) and, with SIGNED_EN = 0, that signed_op = 1 with A = 0x9C, B = 7 gives unsigned Q = 22, R = 2.
